// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file types, sizes and address decode
package regfile_pkg;

  localparam int BITWIDTH        = 16;
  localparam int REGADDRBITWIDTH = 4;
  localparam int REGCOUNT        = 2 ** REGADDRBITWIDTH;

  typedef struct packed {
    logic [REGADDRBITWIDTH-1:0] reg_addr;
    logic [BITWIDTH-1:0]        data;
  } wb_entry_t;

  function automatic logic [REGCOUNT-1:0] onehot_decode(input logic [REGADDRBITWIDTH-1:0] addr);
    return REGCOUNT'(1) << addr;
  endfunction

endpackage

// File: rtl/wb_queue_storage.sv
// rtl/wb_queue_storage.sv - writeback entry array, one write port, async head read
module wb_queue_storage
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [PTRW-1:0] wr_idx,
  input  wb_entry_t       wr_entry,
  input  logic [PTRW-1:0] rd_idx,
  output wb_entry_t       rd_entry
);

  wb_entry_t mem [DEPTH];

  // Contents are deliberately unreset; validity is tracked by the control count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/load_writeback_queue.sv
// rtl/load_writeback_queue.sv - load response FIFO retiring into register cells
module load_writeback_queue
  import regfile_pkg::*;
#(
  parameter int BITWIDTH        = regfile_pkg::BITWIDTH,
  parameter int REGADDRBITWIDTH = regfile_pkg::REGADDRBITWIDTH,
  parameter int DEPTH           = 4
) (
  input  logic                          clk,
  input  logic                          clk_en,
  input  logic                          sync_rst,
  input  logic                          Resp_Valid,
  output logic                          Resp_Ready,
  input  logic [BITWIDTH-1:0]           Resp_Data,
  input  logic [REGADDRBITWIDTH-1:0]    Resp_RegAddr,
  input  logic                          ALU_Write_En,
  input  logic [REGADDRBITWIDTH-1:0]    ALU_RegAddr,
  output logic [2**REGADDRBITWIDTH-1:0] Mem_Write_En,
  output logic [BITWIDTH-1:0]           Mem_DataOut,
  output logic [$clog2(DEPTH):0]        Pending_Count,
  output logic                          Queue_Empty
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] wr_ptr;
  logic [CNTW-1:0] count;

  logic      empty;
  logic      full;
  logic      push;
  logic      pop;
  logic      collide;
  wb_entry_t in_entry;
  wb_entry_t head;

  assign empty = (count == '0);
  assign full  = (count == CNTW'(DEPTH));

  // Ready looks only at the registered count, never at a same-cycle pop.
  assign Resp_Ready = ~full & ~sync_rst;
  assign push       = Resp_Valid & Resp_Ready & clk_en;

  assign in_entry.reg_addr = Resp_RegAddr;
  assign in_entry.data     = Resp_Data;

  wb_queue_storage #(
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_storage (
    .clk      (clk),
    .wr_en    (push),
    .wr_idx   (wr_ptr),
    .wr_entry (in_entry),
    .rd_idx   (rd_ptr),
    .rd_entry (head)
  );

  // A head that targets the register the ALU is writing this cycle waits.
  assign collide = ALU_Write_En & (ALU_RegAddr == head.reg_addr);
  assign pop     = clk_en & ~empty & ~collide & ~sync_rst;

  assign Mem_Write_En  = pop ? onehot_decode(head.reg_addr) : '0;
  assign Mem_DataOut   = (~empty & ~sync_rst) ? head.data : '0;
  assign Pending_Count = sync_rst ? '0 : count;
  assign Queue_Empty   = sync_rst | empty;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clk_en) begin
      if (push) begin
        wr_ptr <= wr_ptr + PTRW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTRW'(1);
      end
      if (push && !pop) begin
        count <= count + CNTW'(1);
      end else if (pop && !push) begin
        count <= count - CNTW'(1);
      end
    end
  end

endmodule

// File: tb/tb_load_writeback_queue.sv
// tb/tb_load_writeback_queue.sv - directed self-checking bench for load_writeback_queue
module tb_load_writeback_queue;

  logic        clk;
  logic        clk_en;
  logic        sync_rst;
  logic        Resp_Valid;
  logic        Resp_Ready;
  logic [15:0] Resp_Data;
  logic [3:0]  Resp_RegAddr;
  logic        ALU_Write_En;
  logic [3:0]  ALU_RegAddr;
  logic [15:0] Mem_Write_En;
  logic [15:0] Mem_DataOut;
  logic [2:0]  Pending_Count;
  logic        Queue_Empty;

  int checks   = 0;
  int failures = 0;

  load_writeback_queue #(
    .BITWIDTH        (16),
    .REGADDRBITWIDTH (4),
    .DEPTH           (4)
  ) dut (
    .clk           (clk),
    .clk_en        (clk_en),
    .sync_rst      (sync_rst),
    .Resp_Valid    (Resp_Valid),
    .Resp_Ready    (Resp_Ready),
    .Resp_Data     (Resp_Data),
    .Resp_RegAddr  (Resp_RegAddr),
    .ALU_Write_En  (ALU_Write_En),
    .ALU_RegAddr   (ALU_RegAddr),
    .Mem_Write_En  (Mem_Write_En),
    .Mem_DataOut   (Mem_DataOut),
    .Pending_Count (Pending_Count),
    .Queue_Empty   (Queue_Empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [3:0] addr, input logic [15:0] data);
    Resp_Valid   = 1'b1;
    Resp_RegAddr = addr;
    Resp_Data    = data;
    tick();
    Resp_Valid = 1'b0;
  endtask

  logic [3:0]  exp_addr [$];
  logic [15:0] exp_data [$];

  initial begin
    clk_en = 1'b1; sync_rst = 1'b1; Resp_Valid = 1'b0; Resp_Data = '0;
    Resp_RegAddr = '0; ALU_Write_En = 1'b0; ALU_RegAddr = '0;

    // Reset state
    tick(); tick();
    #1;
    check("rst_ready", 32'(Resp_Ready), 32'd0);
    check("rst_empty", 32'(Queue_Empty), 32'd1);
    check("rst_count", 32'(Pending_Count), 32'd0);
    check("rst_mwe", 32'(Mem_Write_En), 32'd0);
    check("rst_dout", 32'(Mem_DataOut), 32'd0);
    sync_rst = 1'b0;
    #1;
    check("t1_ready", 32'(Resp_Ready), 32'd1);

    // Single push of R3 retires the following cycle for exactly one cycle
    push_one(4'd3, 16'h1234);
    #1;
    check("t1_mwe", 32'(Mem_Write_En), 32'h0008);
    check("t1_dout", 32'(Mem_DataOut), 32'h1234);
    check("t1_count", 32'(Pending_Count), 32'd1);
    tick();
    check("t1_mwe_after", 32'(Mem_Write_En), 32'd0);
    check("t1_empty_after", 32'(Queue_Empty), 32'd1);

    // Fill while the ALU blocks the R1 head; a fifth response must be refused
    ALU_Write_En = 1'b1; ALU_RegAddr = 4'd1;
    for (int i = 1; i <= 4; i++) push_one(4'(i), 16'hA000 + 16'(i));
    #1;
    check("t2_count_full", 32'(Pending_Count), 32'd4);
    check("t2_ready_full", 32'(Resp_Ready), 32'd0);
    check("t2_mwe_blocked", 32'(Mem_Write_En), 32'd0);
    push_one(4'd9, 16'h9999);
    check("t2_count_5th", 32'(Pending_Count), 32'd4);
    ALU_Write_En = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      check($sformatf("t2_mwe_%0d", i), 32'(Mem_Write_En), 32'(16'h1 << i));
      check($sformatf("t2_dout_%0d", i), 32'(Mem_DataOut), 32'(16'hA000 + 16'(i)));
      tick();
    end
    check("t2_empty", 32'(Queue_Empty), 32'd1);
    check("t2_mwe_drained", 32'(Mem_Write_En), 32'd0);

    // Collision held three cycles on R5, then released
    ALU_Write_En = 1'b1; ALU_RegAddr = 4'd5;
    push_one(4'd5, 16'h0555);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_hold_%0d", i), 32'(Mem_Write_En), 32'd0);
      tick();
    end
    ALU_Write_En = 1'b0;
    #1;
    check("t3_release", 32'(Mem_Write_En), 32'h0020);
    check("t3_release_dout", 32'(Mem_DataOut), 32'h0555);
    tick();
    ALU_Write_En = 1'b1; ALU_RegAddr = 4'd6;
    push_one(4'd5, 16'h0556);
    check("t3_nocollide", 32'(Mem_Write_En), 32'h0020);
    check("t3_nocollide_dout", 32'(Mem_DataOut), 32'h0556);
    tick();
    check("t3_empty", 32'(Queue_Empty), 32'd1);

    // Occupancy 2 with six simultaneous push/pop cycles; pointers wrap past index 3
    ALU_Write_En = 1'b1; ALU_RegAddr = 4'd7;
    push_one(4'd7, 16'h0700); exp_addr.push_back(4'd7); exp_data.push_back(16'h0700);
    push_one(4'd8, 16'h0800); exp_addr.push_back(4'd8); exp_data.push_back(16'h0800);
    ALU_Write_En = 1'b0;
    for (int i = 0; i < 6; i++) begin
      Resp_Valid = 1'b1; Resp_RegAddr = 4'(9 + i); Resp_Data = 16'h0900 + 16'(i);
      #1;
      check($sformatf("t4_count_%0d", i), 32'(Pending_Count), 32'd2);
      check($sformatf("t4_mwe_%0d", i), 32'(Mem_Write_En), 32'(16'h1 << exp_addr[0]));
      check($sformatf("t4_dout_%0d", i), 32'(Mem_DataOut), 32'(exp_data[0]));
      void'(exp_addr.pop_front()); void'(exp_data.pop_front());
      exp_addr.push_back(4'(9 + i)); exp_data.push_back(16'h0900 + 16'(i));
      tick();
    end
    Resp_Valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("t4_drain_mwe_%0d", i), 32'(Mem_Write_En), 32'(16'h1 << exp_addr[0]));
      check($sformatf("t4_drain_dout_%0d", i), 32'(Mem_DataOut), 32'(exp_data[0]));
      void'(exp_addr.pop_front()); void'(exp_data.pop_front());
      tick();
    end
    check("t4_empty", 32'(Queue_Empty), 32'd1);

    // Reset with three entries queued discards them
    ALU_Write_En = 1'b1; ALU_RegAddr = 4'd1;
    push_one(4'd1, 16'h1111);
    push_one(4'd2, 16'h2222);
    push_one(4'd3, 16'h3333);
    check("t5_count_pre", 32'(Pending_Count), 32'd3);
    sync_rst = 1'b1; ALU_Write_En = 1'b0;
    #1;
    check("t5_mwe_in_rst", 32'(Mem_Write_En), 32'd0);
    check("t5_ready_in_rst", 32'(Resp_Ready), 32'd0);
    tick();
    sync_rst = 1'b0;
    #1;
    check("t5_empty", 32'(Queue_Empty), 32'd1);
    check("t5_count", 32'(Pending_Count), 32'd0);
    check("t5_ready", 32'(Resp_Ready), 32'd1);
    check("t5_mwe", 32'(Mem_Write_En), 32'd0);
    tick();
    check("t5_no_stale", 32'(Mem_Write_En), 32'd0);

    // clk_en low freezes push and pop
    ALU_Write_En = 1'b1; ALU_RegAddr = 4'd10;
    push_one(4'd10, 16'h0A0A);
    push_one(4'd11, 16'h0B0B);
    ALU_Write_En = 1'b0; clk_en = 1'b0;
    Resp_Valid = 1'b1; Resp_RegAddr = 4'd12; Resp_Data = 16'h0C0C;
    #1;
    check("t6_mwe_off", 32'(Mem_Write_En), 32'd0);
    check("t6_ready_off", 32'(Resp_Ready), 32'd1);
    tick(); tick();
    check("t6_count_off", 32'(Pending_Count), 32'd2);
    Resp_Valid = 1'b0; clk_en = 1'b1;
    #1;
    check("t6_mwe_a", 32'(Mem_Write_En), 32'h0400);
    check("t6_dout_a", 32'(Mem_DataOut), 32'h0A0A);
    tick();
    check("t6_mwe_b", 32'(Mem_Write_En), 32'h0800);
    check("t6_dout_b", 32'(Mem_DataOut), 32'h0B0B);
    tick();
    check("t6_empty", 32'(Queue_Empty), 32'd1);
    check("t6_mwe_end", 32'(Mem_Write_En), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
